axi_stream_rr_arbiter: RTL
==========================

Name: axi_stream_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-Stream master (downstream) port between N AXI-Stream slave (upstream) ports.
- Grant is held from the first accepted beat of a packet through its TLAST beat, so packets are never interleaved.
- Sits in front of any shared stream consumer (DMA writer, serializer, router egress).
- Output port obeys the codebase AXI-Stream master property set: stable payload while valid && !ready, and no valid during reset.

Parameters:
- NUM_PORTS, 4: number of slave ports; 2..16.
- BYTE_WIDTH, 4: TDATA width in bytes.
- ID_WIDTH, 1: TID width; ≥1, tie off unused bits.
- DEST_WIDTH, 1: TDEST width; ≥1.
- USER_WIDTH, 1: TUSER width; ≥1.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous reset, active-high.
- s_tvalid  in  NUM_PORTS  per-port TVALID.
- s_tready  out  NUM_PORTS  per-port TREADY.
- s_tdata  in  NUM_PORTS*8*BYTE_WIDTH  flattened, port i at slice i.
- s_tstrb, s_tkeep  in  NUM_PORTS*BYTE_WIDTH  flattened.
- s_tlast  in  NUM_PORTS  per-port TLAST.
- s_tid / s_tdest / s_tuser  in  NUM_PORTS*ID/DEST/USER_WIDTH  flattened.
- m_tvalid  out  1; m_tready  in  1.
- m_tdata  out  8*BYTE_WIDTH; m_tstrb, m_tkeep  out  BYTE_WIDTH; m_tlast  out  1.
- m_tid / m_tdest / m_tuser  out  ID/DEST/USER_WIDTH.
- grant  out  clog2(NUM_PORTS)  index of the current/last granted port.
- busy  out  1  high while in LOCKED.

Behaviour:
- FSM states: IDLE, LOCKED. Reset → IDLE, grant = NUM_PORTS-1 (port 0 has highest priority first), busy = 0.
- IDLE:
  - m_tvalid = 0; all s_tready = 0.
  - If any s_tvalid: winner = first set bit scanning grant+1, grant+2, … modulo NUM_PORTS.
  - Register grant ← winner and go to LOCKED next cycle.
  - Arbitration latency is one cycle; no data moves in IDLE.
- LOCKED:
  - m_tvalid = s_tvalid[grant]; m_t* payload = slice[grant] (combinational mux).
  - s_tready[grant] = m_tready; all other s_tready = 0.
  - Beat accepted when m_tvalid && m_tready.
  - Accepted beat with m_tlast = 1 → IDLE next cycle, grant retained for the round-robin pointer.
  - Accepted beat with m_tlast = 0 → stay in LOCKED.
- Upstream bubbles (s_tvalid[grant] low mid-packet): stay in LOCKED, m_tvalid = 0. Grant is never revoked mid-packet, and there is no timeout.
- Back-to-back packets: one idle cycle between a TLAST beat and the next packet's first beat, whichever port wins.
- Single-beat packets (tlast on the first beat) are legal: IDLE → LOCKED → IDLE.
- Requests in IDLE are sampled only in the cycle the decision is made. A port whose valid drops before LOCKED simply presents m_tvalid = 0; the arbiter waits for its packet.
- Reset mid-packet:
  - Immediately forces IDLE; m_tvalid = 0 and all s_tready = 0 in the reset cycle, since outputs are gated by reset.
  - The partial packet is abandoned; upstream and downstream are also reset by system convention.
- Stability: payload stability while m_tvalid && !m_tready follows from the locked grant plus upstream compliance. The arbiter never changes grant while m_tvalid && !m_tready.
- Signals are passed through unmodified. TSTRB ⊆ TKEEP is preserved.
- Combinational paths: m_tready → s_tready and s_* → m_*. No registered data path.

Decomposition:
- Shared package axi_stream_pkg:
  - Localparams for the slice widths: DATA_W = 8*BYTE_WIDTH, and the strobe width.
  - A function for the round-robin next-index search.
- Natural sub-module: rr_priority_select (request vector + last grant → winner index + any_req), purely combinational, reusable by future AXI arbiters.
- Mux and FSM live in the top module.
- Verification binds axi_stream_master_monitor on the m_* port.

Test Plan:
- Reset then s_tvalid = 4'b1111, every packet 1 beat, m_tready = 1 → grant sequence 0,1,2,3,0; one beat every 2 cycles; m_tdata matches the granted port.
- Port 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with tlast on the third) while port 1 requests → m_tdata = A0, A1, A2 uninterrupted; port 1 is granted only after the tlast handshake plus the IDLE cycle.
- During LOCKED on port 0, hold m_tready = 0 for 5 cycles with s_tvalid[0] = 1 → m_t* stable; s_tready[0] = 0; other s_tready = 0; grant unchanged.
- Only port 3 requesting, grant = 3 after a prior packet → port 3 is re-granted (wrap-around search), not starved.
- Assert reset in the second beat of a 4-beat packet → next cycle m_tvalid = 0, busy = 0, grant = NUM_PORTS-1; the first post-reset request from port 0 is granted first.
- Mid-packet upstream bubble (s_tvalid[1] low 3 cycles) with port 0 requesting → stays LOCKED on 1; m_tvalid = 0 during the bubble; port 0 waits.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream helpers: slice-width helpers, FSM encodings and the
// round-robin next-index search used by the stream arbiters.
package axi_stream_pkg;

  localparam int MAX_PORTS      = 16;
  localparam int DEFAULT_BYTE_W = 4;
  localparam int DATA_W         = 8 * DEFAULT_BYTE_W;
  localparam int STRB_W         = DEFAULT_BYTE_W;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  function automatic int data_width(input int byte_width);
    return 8 * byte_width;
  endfunction

  function automatic int strb_width(input int byte_width);
    return byte_width;
  endfunction

  // Scans last+1, last+2, ... modulo n; walking from the far end toward the
  // near end lets the closest requester overwrite any earlier candidate.
  function automatic int rr_next(input logic [MAX_PORTS-1:0] req,
                                 input int last, input int n,
                                 output logic any);
    int win;
    int cand;
    win = last;
    any = 1'b0;
    for (int k = n; k >= 1; k--) begin
      cand = (last + k) % n;
      if (req[cand[3:0]]) begin
        win = cand;
        any = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: picks the first requester after the
// previously granted index, wrapping modulo NUM_PORTS.
module rr_priority_select
  import axi_stream_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_req
);

  logic [MAX_PORTS-1:0] req_ext;
  int                   win_idx;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    any_req                  = 1'b0;
    win_idx                  = rr_next(req_ext, int'(last_grant), NUM_PORTS, any_req);
    winner                   = IDX_W'(win_idx);
  end

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream master port between
// NUM_PORTS slave ports; a grant is held from the first beat through TLAST.
module axi_stream_rr_arbiter
  import axi_stream_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int BYTE_WIDTH = 4,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  output logic [NUM_PORTS-1:0]              s_tready,
  input  logic [NUM_PORTS*8*BYTE_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*BYTE_WIDTH-1:0]   s_tstrb,
  input  logic [NUM_PORTS*BYTE_WIDTH-1:0]   s_tkeep,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]     s_tid,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]   s_tdest,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]   s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [8*BYTE_WIDTH-1:0]           m_tdata,
  output logic [BYTE_WIDTH-1:0]             m_tstrb,
  output logic [BYTE_WIDTH-1:0]             m_tkeep,
  output logic                              m_tlast,
  output logic [ID_WIDTH-1:0]               m_tid,
  output logic [DEST_WIDTH-1:0]             m_tdest,
  output logic [USER_WIDTH-1:0]             m_tuser,
  output logic [$clog2(NUM_PORTS)-1:0]      grant,
  output logic                              busy
);

  localparam int IDX_W   = $clog2(NUM_PORTS);
  localparam int TDATA_W = data_width(BYTE_WIDTH);
  localparam int TSTRB_W = strb_width(BYTE_WIDTH);

  logic [0:0]       state;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             locked_live;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_select (
    .req        (s_tvalid),
    .last_grant (grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Handshakes are gated by reset so nothing moves in the reset cycle even
  // when the registered state is still LOCKED.
  assign locked_live = (state == ARB_LOCKED) && !reset;

  always_comb begin
    m_tvalid = locked_live && s_tvalid[grant_q];
    s_tready = '0;
    if (locked_live) begin
      s_tready[grant_q] = m_tready;
    end
    m_tdata = s_tdata[int'(grant_q)*TDATA_W +: TDATA_W];
    m_tstrb = s_tstrb[int'(grant_q)*TSTRB_W +: TSTRB_W];
    m_tkeep = s_tkeep[int'(grant_q)*TSTRB_W +: TSTRB_W];
    m_tlast = s_tlast[grant_q];
    m_tid   = s_tid[int'(grant_q)*ID_WIDTH +: ID_WIDTH];
    m_tdest = s_tdest[int'(grant_q)*DEST_WIDTH +: DEST_WIDTH];
    m_tuser = s_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
  end

  // Grant only moves in IDLE, so it can never change under a stalled beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      grant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            state   <= ARB_LOCKED;
          end
        end
        default: begin
          if (m_tvalid && m_tready && m_tlast) begin
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state == ARB_LOCKED);

endmodule
